// File: rtl/operand_pkg.sv
// Shared types and defaults for the switch operand loader.
package operand_pkg;

  localparam int DEFAULT_DATA_W          = 4;
  // 10 ms of stable samples at 50 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  typedef enum logic [1:0] {
    WAIT_X = 2'd0,
    WAIT_Y = 2'd1,
    FULL   = 2'd2
  } load_state_e;

endpackage : operand_pkg

// File: rtl/key_debouncer.sv
// Pushbutton front end: two-flop synchroniser, stability-count debouncer,
// and a one-cycle press pulse on each debounced 1->0 transition.
module key_debouncer
  import operand_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_key;
  logic             level_q;
  logic             level_prev;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic [CNT_W-1:0] arm_cnt;

  // Two-flop synchroniser; flops rest at the released level.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync_key  <= 1'b1;
    end else begin
      sync_meta <= key_n;
      sync_key  <= sync_meta;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing
  // samples; any sample matching the current level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b1;
      cnt     <= '0;
    end else if (sync_key != level_q) begin
      if (cnt == CNT_MAX) begin
        level_q <= sync_key;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Press events are suppressed after reset until the key has been seen
  // released for a full debounce window, so a key held through reset must
  // be let go and pressed again before it counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else if (!armed) begin
      if (sync_key && level_q) begin
        if (arm_cnt == CNT_MAX) begin
          armed   <= 1'b1;
          arm_cnt <= '0;
        end else begin
          arm_cnt <= arm_cnt + CNT_W'(1);
        end
      end else begin
        arm_cnt <= '0;
      end
    end
  end

  // Delayed copy of the debounced level for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) level_prev <= 1'b1;
    else       level_prev <= level_q;
  end

  assign level = level_q;
  assign press = armed & level_prev & ~level_q;

endmodule : key_debouncer

// File: rtl/switch_operand_loader.sv
// Loads operand X then Y from the switch nibble on successive debounced
// key presses and holds them for the downstream 2-to-1 mux.
module switch_operand_loader
  import operand_pkg::*;
#(
  parameter int DATA_W          = DEFAULT_DATA_W,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              load_key_n,
  input  logic              clear,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic              pair_valid,
  output logic              next_is_y,
  output logic              load_pulse
);

  load_state_e       state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              pv_q, pv_d;
  logic              load_pulse_q;
  logic              capture;
  logic              key_level;
  logic              key_press;
  logic              press_evt;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk   (CLOCK_50),
    .reset (reset),
    .key_n (load_key_n),
    .level (key_level),
    .press (key_press)
  );

  // A capture only happens while the debounced key is actually down.
  assign press_evt = key_press & ~key_level;

  // Next-state and operand update; clear overrides a coincident press.
  // NOTE: every signal gets a default before any branch so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pv_d    = pv_q;
    capture = 1'b0;
    if (clear) begin
      state_d = WAIT_X;
      x_d     = '0;
      y_d     = '0;
      pv_d    = 1'b0;
    end else if (press_evt) begin
      capture = 1'b1;
      case (state_q)
        WAIT_X: begin
          x_d     = sw_data;
          state_d = WAIT_Y;
        end
        WAIT_Y: begin
          y_d     = sw_data;
          pv_d    = 1'b1;
          state_d = FULL;
        end
        FULL: begin
          // Start a new pair; Y keeps its old value until reloaded.
          x_d     = sw_data;
          pv_d    = 1'b0;
          state_d = WAIT_Y;
        end
        default: begin
          capture = 1'b0;
          state_d = WAIT_X;
        end
      endcase
    end
  end

  // State, operand registers and the capture strobe.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= WAIT_X;
      x_q          <= '0;
      y_q          <= '0;
      pv_q         <= 1'b0;
      load_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pv_q         <= pv_d;
      load_pulse_q <= capture;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign pair_valid = pv_q;
  assign next_is_y  = (state_q == WAIT_Y);
  assign load_pulse = load_pulse_q;

endmodule : switch_operand_loader

// File: doc/switch_operand_loader.md
Name: switch_operand_loader

Overview:
- Upstream operand stage for the 4-bit 2-to-1 switch multiplexer.
- Captures two 4-bit operands, X then Y, from one switch nibble. Each capture is triggered by a debounced pushbutton press.
- Holds both operands stable so the mux can select between them.
- Flags when a complete X/Y pair has been loaded.

Parameters:
- DATA_W, 4: operand width in bits.
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples needed to accept a button level change (10 ms at 50 MHz).

Ports:
- CLOCK_50, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- sw_data, input, DATA_W: raw switch nibble (SW3-0), the operand source.
- load_key_n, input, 1: raw pushbutton (KEY0), active-low and asynchronous to the clock.
- clear, input, 1: synchronous clear, active-high, already clean.
- x_out, output, DATA_W: captured operand X, feeds mux input X.
- y_out, output, DATA_W: captured operand Y, feeds mux input Y.
- pair_valid, output, 1: high while both operands hold values from the current load cycle.
- next_is_y, output, 1: 0 means the next press loads X; 1 means it loads Y. Drives a status LED.
- load_pulse, output, 1: one-cycle strobe on each capture.

Behaviour:
- Reset is synchronous and active-high. Clock is CLOCK_50 only. Reset values:
  - x_out = 0, y_out = 0.
  - pair_valid = 0, next_is_y = 0, load_pulse = 0.
  - FSM state = WAIT_X.
  - Debounced level = 1 (released); debounce counter = 0; synchroniser flops = 1.
- Synchroniser: load_key_n passes through 2 flops before use.
- Debounce:
  - While the synchronised level differs from the debounced level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level updates and the counter clears.
  - Any sample equal to the debounced level clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Press event: one-cycle pulse when the debounced level goes 1→0. Release produces no event.
- FSM, evaluated only on a press event:
  - WAIT_X: x_out <= sw_data; go to WAIT_Y.
  - WAIT_Y: y_out <= sw_data; pair_valid <= 1; go to FULL.
  - FULL: x_out <= sw_data; pair_valid <= 0; go to WAIT_Y. This starts a new pair; y_out keeps its old value.
- next_is_y = 1 in WAIT_Y, 0 in WAIT_X and FULL.
- load_pulse is high in the cycle after every capture edge, for exactly 1 cycle.
- Latency: the first raw low sample reaches x_out/y_out after 2 (sync) + DEBOUNCE_CYCLES + 1 (capture) rising edges.
- sw_data is sampled only on the capture edge. Switch changes at any other time have no effect on the outputs.
- clear:
  - Zeroes x_out and y_out, clears pair_valid, and forces WAIT_X.
  - The debouncer is unaffected.
  - If clear and a press event occur in the same cycle, clear wins and the press is dropped.
- reset has priority over clear.
- Reset mid-debounce discards the partial count. Reset while the key is held requires a release and a new press before the next capture.
- Counter width: clog2(DEBOUNCE_CYCLES). The counter never wraps because it saturates by clearing.

Decomposition:
- Shared package `operand_pkg`:
  - DATA_W default.
  - FSM state enum: WAIT_X=2'd0, WAIT_Y=2'd1, FULL=2'd2.
  - Default DEBOUNCE_CYCLES constant.
- One sub-module, `key_debouncer`, parameterised by DEBOUNCE_CYCLES:
  - Contains the synchroniser, the counter and the falling-edge pulse generator.
  - Outputs the debounced level and a press pulse.
- The top level holds the FSM and the operand registers.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
1. Reset, then sw_data=4'hA and hold load_key_n low 10 cycles → x_out=4'hA exactly 7 edges after the first low sample; load_pulse high 1 cycle; next_is_y=1; pair_valid=0.
2. After release, sw_data=4'h5, press → y_out=4'h5, pair_valid=1, next_is_y=0. Then sw_data=4'h3, press → x_out=4'h3, y_out stays 4'h5, pair_valid=0.
3. Glitch: load_key_n low for 3 cycles, high, repeated 5 times → no load_pulse, outputs unchanged.
4. Press held 50 cycles → exactly one capture; no capture on release.
5. clear asserted in the same cycle as a press event in WAIT_Y → x_out=0, y_out=0, pair_valid=0, state WAIT_X, no load_pulse.
6. Assert reset at debounce count 2 during a press, then release reset while the key is still low → no capture until the key is released and pressed again.
